conv_vec_stream_tx: RTL

//  Transmitter side of the conv input stream: buffers whole N-word input vectors and drives
//  x_data/x_valid/x_ready into a conv_<N>_<M>_<T>_<P> engine.
//  Two ping-pong banks: the host loads one bank while the other streams out.

---
 rtl/conv_tx_pkg.sv | 17 +
 rtl/conv_tx_bank_mem.sv | 29 ++
 rtl/conv_vec_stream_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/conv_tx_pkg.sv
// Shared types and helpers for the conv vector stream transmitter.
// Optional feature macro used by this block: CONV_TX_LAST_EN (adds the x_last output).
package conv_tx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } tx_state_t;

  localparam int FRAME_CNT_W = 16;

  // Address width for a bank of the given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_tx_bank_mem.sv
// Two-bank ping-pong word store: one synchronous write port, one combinational read port.
module conv_tx_bank_mem #(
  parameter int T  = 16,
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [T-1:0]  wdata,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [T-1:0]  rdata
);

  logic [T-1:0] mem [2][N];

  // NOTE: the array has no reset; the full flags guarantee every word is
  // written before the reader can reach it, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/conv_vec_stream_tx.sv
// Buffers whole N-word vectors in two ping-pong banks and streams them to a conv engine.
// Define CONV_TX_LAST_EN to add the x_last output marking the final word of each vector.
module conv_vec_stream_tx
  import conv_tx_pkg::*;
#(
  parameter int T = 16,
  parameter int N = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [T-1:0]           wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [T-1:0]           x_data,
  output logic                   x_valid,
  input  logic                   x_ready,
  output logic [FRAME_CNT_W-1:0] frames_sent
`ifdef CONV_TX_LAST_EN
  ,
  output logic                   x_last
`endif
);

  localparam int            AW        = addr_w(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  tx_state_t     state_q, state_d;
  logic [1:0]    full_q;
  logic          wbank_q, rbank_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic          wr_fire, wr_wrap;
  logic          out_free, load, rd_wrap;
  logic          frame_done;
  logic [T-1:0]  rd_word;

  assign wr_ready = !full_q[wbank_q];
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_wrap  = wr_fire && (waddr_q == LAST_ADDR);

  assign out_free = !x_valid || x_ready;
  assign rd_wrap  = load && (raddr_q == LAST_ADDR);

  // The output register holds word N-1 exactly when it is valid and the read
  // pointer has already wrapped back to 0, so no separate end-of-frame flop is needed.
  assign frame_done = x_valid && x_ready && (raddr_q == '0);

  conv_tx_bank_mem #(
    .T  (T),
    .N  (N),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .wbank (wbank_q),
    .waddr (waddr_q),
    .wdata (wr_data),
    .rbank (rbank_q),
    .raddr (raddr_q),
    .rdata (rd_word)
  );

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        load = out_free;
        if (load && (raddr_q == LAST_ADDR)) begin
          state_d = full_q[~rbank_q] ? STREAM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  // reset_n is expected to arrive with its release already synchronised to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbank_q <= 1'b0;
      waddr_q <= '0;
    end else if (wr_fire) begin
      if (wr_wrap) begin
        waddr_q <= '0;
        wbank_q <= ~wbank_q;
      end else begin
        waddr_q <= waddr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rbank_q <= 1'b0;
      raddr_q <= '0;
    end else if (load) begin
      if (rd_wrap) begin
        raddr_q <= '0;
        rbank_q <= ~rbank_q;
      end else begin
        raddr_q <= raddr_q + AW'(1);
      end
    end
  end

  // Writer only ever sets an empty bank and reader only clears a full one,
  // so the two updates can never target the same bit in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= '0;
    end else begin
      if (wr_wrap) begin
        full_q[wbank_q] <= 1'b1;
      end
      if (rd_wrap) begin
        full_q[rbank_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_valid <= 1'b0;
      x_data  <= '0;
    end else if (out_free) begin
      if (load) begin
        x_valid <= 1'b1;
        x_data  <= rd_word;
      end else begin
        x_valid <= 1'b0;
        x_data  <= '0;
      end
    end
  end

`ifdef CONV_TX_LAST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_last <= 1'b0;
    end else if (out_free) begin
      x_last <= rd_wrap;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_sent <= '0;
    end else if (frame_done) begin
      frames_sent <= frames_sent + FRAME_CNT_W'(1);
    end
  end

endmodule
